// File: rtl/leak_integrate_unit.sv
// Leak/integrate/fire sweep over the shared membrane-potential RAM.
// One start pulse walks every neuron (read, leak, threshold, write back) and ends with a done pulse.
module leak_integrate_unit #(
  parameter int N_NEURONS  = 64,
  parameter int ADDR_W     = 6,
  parameter int VMEM_W     = 16,
  parameter int LEAK_SHIFT = 4,
  parameter int V_TH       = 256,
  parameter int V_RESET    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       tu,
  output logic              done,
  output logic              busy,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [VMEM_W-1:0] mem_rd_data,
  output logic [VMEM_W-1:0] mem_wr_data,
  output logic              spike_valid,
  output logic [ADDR_W-1:0] spike_id,
  output logic [15:0]       spike_tu
);

  typedef enum logic [1:0] {IDLE, RD, WB, DONE} state_t;

  localparam logic [ADDR_W-1:0]        LAST  = ADDR_W'(N_NEURONS - 1);
  localparam logic signed [VMEM_W-1:0] TH    = VMEM_W'(V_TH);
  localparam logic signed [VMEM_W-1:0] RST_V = VMEM_W'(V_RESET);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic signed [VMEM_W-1:0] v, v_new;
  logic                fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RD;
          idx   <= '0;
        end
        RD:   state <= WB;
        WB: begin
          if (idx == LAST) state <= DONE;
          else begin
            state <= RD;
            idx   <= idx + ADDR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is only meaningful in WB; arithmetic shift keeps leak toward -inf for negatives.
  assign v     = mem_rd_data;
  assign v_new = v - (v >>> LEAK_SHIFT);
  assign fire  = (state == WB) && (v_new >= TH);

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign mem_rd_en   = (state == RD);
  assign mem_wr_en   = (state == WB);
  assign mem_addr    = (mem_rd_en || mem_wr_en) ? idx : '0;
  assign mem_wr_data = !mem_wr_en ? '0 : (fire ? RST_V : v_new);
  assign spike_valid = fire;
  assign spike_id    = fire ? idx : '0;
  assign spike_tu    = fire ? tu : '0;

endmodule

// File: tb/tb_leak_integrate_unit.sv
// Scoreboard bench for leak_integrate_unit with a 4-neuron RAM model.
module tb_leak_integrate_unit;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
    logic        spk;
    logic [15:0] tu;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] tu = '0;
  logic        done, busy, mem_rd_en, mem_wr_en, spike_valid;
  logic [5:0]  mem_addr, spike_id;
  logic [15:0] rd_data = '0, mem_wr_data, spike_tu;

  logic [15:0] ram [0:3];
  int          exp_ram [0:3];
  exp_t        sbq [$];
  int          n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0;
  logic        prev_rd = 1'b0;
  logic [5:0]  prev_addr = '0;

  leak_integrate_unit #(
    .N_NEURONS(4), .ADDR_W(6), .VMEM_W(16), .LEAK_SHIFT(4), .V_TH(256), .V_RESET(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tu(tu), .done(done), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_rd_data(rd_data), .mem_wr_data(mem_wr_data), .spike_valid(spike_valid),
    .spike_id(spike_id), .spike_tu(spike_tu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) rd_data <= ram[mem_addr[1:0]];
    if (mem_wr_en) ram[mem_addr[1:0]] <= mem_wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int leak_of(input int v);
    return (v >= 0) ? v / 16 : -((-v + 15) / 16);
  endfunction

  task automatic load(input int a0, input int a1, input int a2, input int a3);
    exp_ram[0] = a0; exp_ram[1] = a1; exp_ram[2] = a2; exp_ram[3] = a3;
    for (int i = 0; i < 4; i++) ram[i] = 16'(exp_ram[i]);
  endtask

  task automatic push_sweep(input logic [15:0] t);
    for (int k = 0; k < 4; k++) begin
      int   vn;
      exp_t e;
      vn     = exp_ram[k] - leak_of(exp_ram[k]);
      e.addr = 6'(k);
      e.spk  = (vn >= 256);
      e.data = e.spk ? 16'd0 : 16'(vn);
      e.tu   = t;
      sbq.push_back(e);
      exp_ram[k] = e.spk ? 0 : vn;
    end
  endtask

  task automatic chk_ram(input string nm);
    for (int i = 0; i < 4; i++) chk(nm, {58'd0, 6'(i), ram[i]}, {58'd0, 6'(i), 16'(exp_ram[i])});
  endtask

  task automatic run_sweep(input logic [15:0] t, input string nm);
    tu = t;
    push_sweep(t);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk({nm, "_busy"}, 64'(busy), 64'(k <= 9));
      chk({nm, "_done"}, 64'(done), 64'(k == 9));
    end
    chk({nm, "_sb_empty"}, 64'(sbq.size()), 0);
    chk_ram({nm, "_ram"});
  endtask

  // Protocol and write-data scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (rst) prev_rd <= 1'b0;
    else begin
      chk("rd_wr_overlap", 64'(mem_rd_en && mem_wr_en), 0);
      if (mem_wr_en) begin
        chk("wr_after_rd", {57'd0, prev_rd, prev_addr}, {57'd0, 1'b1, mem_addr});
        if (sbq.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          chk("wr_addr", 64'(mem_addr), 64'(sbq[0].addr));
          chk("wr_data", 64'(mem_wr_data), 64'(sbq[0].data));
          chk("spike", {41'd0, spike_valid, spike_id, spike_tu},
              {41'd0, sbq[0].spk, sbq[0].spk ? sbq[0].addr : 6'd0, sbq[0].spk ? sbq[0].tu : 16'd0});
          void'(sbq.pop_front());
        end
      end else begin
        chk("quiet_outside_wb", {33'd0, spike_valid, spike_id, spike_tu, mem_wr_data}, 0);
      end
      prev_rd   <= mem_rd_en;
      prev_addr <= mem_addr;
    end
  end

  initial begin
    int d0;
    logic [63:0] outs;
    load(11, 22, 33, 44);
    #12;
    outs = {done, busy, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, spike_valid, spike_id, spike_tu};
    chk("reset_outputs", outs, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Idle: nothing moves without start
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      outs = {done, busy, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, spike_valid, spike_id, spike_tu};
      chk("idle_outputs", outs, 0);
    end
    chk_ram("idle_ram");

    // Decay without spikes
    load(100, -100, 0, 16);
    run_sweep(16'd3, "decay");
    chk("decay_v0", 64'(ram[0]), 64'(16'd94));
    chk("decay_v1", 64'(ram[1]), 64'(16'hFFA3));

    // Threshold boundary and most-negative potential
    load(300, 273, 272, -32768);
    run_sweep(16'd7, "thresh");
    chk("thresh_v2", 64'(ram[2]), 64'(16'd255));
    chk("thresh_v3", 64'(ram[3]), 64'(16'h8800));

    // Start pulses while busy are dropped; start right after DONE is taken
    load(1000, 50, -7, 400);
    tu = 16'd9;
    push_sweep(16'd9);
    push_sweep(16'd9);
    @(posedge clk); #1;
    for (int k = 0; k <= 20; k++) begin
      start = (k == 0 || k == 3 || k == 9 || k == 10);
      @(negedge clk);
      if (k >= 1) chk("b2b_done", 64'(done), 64'(k == 9 || k == 19));
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("b2b_sb_empty", 64'(sbq.size()), 0);
    chk_ram("b2b_ram");

    // Reset mid-sweep: neuron 0 written, rest untouched, no done
    load(100, -100, 0, 16);
    tu = 16'd2;
    push_sweep(16'd2);
    exp_ram[1] = -100; exp_ram[2] = 0; exp_ram[3] = 16;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    outs = {done, busy, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, spike_valid, spike_id, spike_tu};
    chk("rst_mid_outputs", outs, 0);
    chk("rst_mid_sb_left", 64'(sbq.size()), 3);
    sbq.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_done", 64'(done_cnt), 64'(d0));
    chk_ram("rst_mid_ram");
    run_sweep(16'd5, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
